fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Optional macro FIFO_WR_ARB_ERR_CNT_EN adds per-requester saturating error counters.
module fifo_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                          wr_clk,
    input  logic                          clear,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         din,
    input  logic                          full,
    input  logic                          almost_full,
    input  logic                          wr_ack,
    input  logic                          wr_err,
    output logic                          busy
`ifdef FIFO_WR_ARB_ERR_CNT_EN
    ,
    output logic [NUM_REQ*8-1:0]          err_cnt
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                             state, state_nxt;
    logic [IW-1:0]                      last_gnt, last_gnt_nxt;
    logic [CW-1:0]                      tcnt, tcnt_nxt;
    logic                               hold, hold_nxt;
    logic [NUM_REQ-1:0]                 gnt_nxt, done_nxt, err_nxt;
    logic                               wr_en_nxt;
    logic [DATA_WIDTH-1:0]              din_nxt;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] slice;
    logic [IW-1:0]                      pick;
    logic                               found;
    int                                 idx;

    assign slice = req_data;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_gnt) + k) % NUM_REQ;
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        tcnt_nxt     = tcnt;
        hold_nxt     = hold;
        gnt_nxt      = '0;
        done_nxt     = '0;
        err_nxt      = '0;
        wr_en_nxt    = 1'b0;
        din_nxt      = din;
        case (state)
            IDLE: begin
                if (hold) begin
                    hold_nxt = 1'b0;
                end else if (found && !full) begin
                    state_nxt     = ISSUE;
                    last_gnt_nxt  = pick;
                    gnt_nxt[pick] = 1'b1;
                    wr_en_nxt     = 1'b1;
                    din_nxt       = slice[pick];
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
                tcnt_nxt  = '0;
            end
            WAIT: begin
                // First WAIT cycle is the response slot; ACK_TIMEOUT more silent cycles time out.
                if (wr_err) begin
                    state_nxt         = RESP;
                    err_nxt[last_gnt] = 1'b1;
                end else if (wr_ack) begin
                    state_nxt          = RESP;
                    done_nxt[last_gnt] = 1'b1;
                end else if (tcnt == CW'(ACK_TIMEOUT)) begin
                    state_nxt         = RESP;
                    err_nxt[last_gnt] = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + CW'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
                hold_nxt  = almost_full;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (clear) begin
            state    <= IDLE;
            last_gnt <= IW'(NUM_REQ - 1);
            tcnt     <= '0;
            hold     <= 1'b0;
            gnt      <= '0;
            done     <= '0;
            err      <= '0;
            wr_en    <= 1'b0;
            din      <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            tcnt     <= tcnt_nxt;
            hold     <= hold_nxt;
            gnt      <= gnt_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            wr_en    <= wr_en_nxt;
            din      <= din_nxt;
            busy     <= (state_nxt != IDLE);
        end
    end

`ifdef FIFO_WR_ARB_ERR_CNT_EN
    logic [NUM_REQ-1:0][7:0] cnt_q;

    assign err_cnt = cnt_q;

    always_ff @(posedge wr_clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (err_nxt[i] && cnt_q[i] != 8'hFF)
                    cnt_q[i] <= cnt_q[i] + 8'd1;
            end
        end
    end
`endif

endmodule
